// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - EX-stage command/result bundle for the multiply/divide sequencer
interface muldiv_seq_if #(parameter int WIDTH = 32);
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] Rdata1;
    logic [WIDTH-1:0] Rdata2;
    logic             mf_req;
    logic             flush;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, funct, Rdata1, Rdata2, mf_req, flush,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, funct, Rdata1, Rdata2, mf_req, flush,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle shift-add multiply / restoring divide owning HI/LO
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic        CLK,
    input  logic        RST,
    muldiv_seq_if.slave m
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] acc, a, b, rs_lat;
    logic [CW-1:0]    cnt;
    logic             busy_q, done_q;
    logic             is_div, div_zero, neg_res, neg_rem;

    logic             sgn;
    logic [WIDTH-1:0] rs_abs, rt_abs;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;

    assign sgn    = (m.funct == F_MULT) || (m.funct == F_DIV);
    assign rs_abs = (sgn && m.Rdata1[WIDTH-1]) ? -m.Rdata1 : m.Rdata1;
    assign rt_abs = (sgn && m.Rdata2[WIDTH-1]) ? -m.Rdata2 : m.Rdata2;

    // Multiply: {acc,a} is the running product, multiplier consumed from a[0].
    assign mul_sum  = {1'b0, acc} + (a[0] ? {1'b0, b} : '0);
    // Divide: acc is the partial remainder, a shifts dividend bits out and quotient bits in.
    assign div_shift = {acc, a[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b};
    assign prod_fix  = neg_res ? -{acc, a} : {acc, a};

    assign m.hi    = hi_q;
    assign m.lo    = lo_q;
    assign m.busy  = busy_q;
    assign m.done  = done_q;
    // Results are already in hi/lo during DONE, so an MFHI/MFLO there need not wait.
    assign m.stall = busy_q & (m.start | (m.mf_req & (state != S_DONE)));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            acc      <= '0;
            a        <= '0;
            b        <= '0;
            rs_lat   <= '0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (m.flush) begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (m.start) begin
                            case (m.funct)
                                F_MTHI: hi_q <= m.Rdata1;
                                F_MTLO: lo_q <= m.Rdata1;
                                F_MULT, F_MULTU: begin
                                    b       <= rs_abs;
                                    a       <= rt_abs;
                                    acc     <= '0;
                                    cnt     <= '0;
                                    neg_res <= sgn & (m.Rdata1[WIDTH-1] ^ m.Rdata2[WIDTH-1]);
                                    is_div  <= 1'b0;
                                    state   <= S_MUL;
                                    busy_q  <= 1'b1;
                                end
                                F_DIV, F_DIVU: begin
                                    a        <= rs_abs;
                                    b        <= rt_abs;
                                    acc      <= '0;
                                    cnt      <= '0;
                                    rs_lat   <= m.Rdata1;
                                    neg_res  <= sgn & (m.Rdata1[WIDTH-1] ^ m.Rdata2[WIDTH-1]);
                                    neg_rem  <= sgn & m.Rdata1[WIDTH-1];
                                    div_zero <= (m.Rdata2 == '0);
                                    is_div   <= 1'b1;
                                    state    <= (m.Rdata2 == '0) ? S_FIX : S_DIV;
                                    busy_q   <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_MUL: begin
                        acc <= mul_sum[WIDTH:1];
                        a   <= {mul_sum[0], a[WIDTH-1:1]};
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
                    end
                    S_DIV: begin
                        if (!div_diff[WIDTH]) begin
                            acc <= div_diff[WIDTH-1:0];
                            a   <= {a[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= div_shift[WIDTH-1:0];
                            a   <= {a[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
                    end
                    S_FIX: begin
                        if (!is_div) begin
                            {hi_q, lo_q} <= prod_fix;
                        end else if (div_zero) begin
                            lo_q <= '1;
                            hi_q <= rs_lat;
                        end else begin
                            lo_q <= neg_res ? -a : a;
                            hi_q <= neg_rem ? -acc : acc;
                        end
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                    S_DONE: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard bench for muldiv_seq
module tb_muldiv_seq;
    localparam int W = 32;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    muldiv_seq_if #(.WIDTH(W)) bus ();
    muldiv_seq #(.WIDTH(W)) dut (.CLK(CLK), .RST(RST), .m(bus));

    int checks = 0;
    int failures = 0;
    logic [63:0] sb_q[$];

    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (f)
            F_MULT:  return sx * sy;
            F_MULTU: return {32'b0, x} * {32'b0, y};
            F_DIV: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            F_DIVU: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
            default: return 64'h0;
        endcase
    endfunction

    function automatic int latency(input logic [5:0] f, input logic [31:0] y);
        return ((f == F_DIV || f == F_DIVU) && y == 0) ? 2 : W + 2;
    endfunction

    function automatic logic [63:0] pop_exp();
        if (sb_q.size() == 0) return 64'hDEAD_DEAD_DEAD_DEAD;
        return sb_q.pop_front();
    endfunction

    task automatic run_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                          output int cyc, output logic [31:0] h, output logic [31:0] l,
                          output logic b1, output logic b33, output logic d_after);
        @(negedge CLK);
        bus.start = 1'b1; bus.funct = f; bus.Rdata1 = x; bus.Rdata2 = y;
        sb_q.push_back(model(f, x, y));
        @(posedge CLK); #1 bus.start = 1'b0;
        cyc = -1; h = '0; l = '0; b1 = 1'b0; b33 = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge CLK);
            if (k == 1) b1 = bus.busy;
            if (k == 33) b33 = bus.busy;
            if (bus.done) begin cyc = k; h = bus.hi; l = bus.lo; break; end
        end
        @(negedge CLK);
        d_after = bus.done;
    endtask

    task automatic mt(input logic [5:0] f, input logic [31:0] v);
        @(negedge CLK);
        bus.start = 1'b1; bus.funct = f; bus.Rdata1 = v;
        @(posedge CLK); #1 bus.start = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b1; bus.mf_req = 1'b1; bus.flush = 1'b0;
        bus.funct = F_MULT; bus.Rdata1 = 32'h5; bus.Rdata2 = 32'h6;
        repeat (3) @(negedge CLK);
        checks++;
        if ({bus.hi, bus.lo, bus.busy, bus.done, bus.stall} !== 67'h0) begin
            failures++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b stall=%b expected all zero",
                     bus.hi, bus.lo, bus.busy, bus.done, bus.stall);
        end
        bus.start = 1'b0; bus.mf_req = 1'b0;
        RST = 1'b1;
    endtask

    task automatic test_mthi_mtlo();
        mt(F_MTHI, 32'h1234_5678);
        mt(F_MTLO, 32'h9ABC_DEF0);
        @(negedge CLK);
        checks++;
        if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'h9ABC_DEF0) begin
            failures++;
            $display("FAIL mthi_mtlo: got hi=%h lo=%h expected hi=12345678 lo=9abcdef0", bus.hi, bus.lo);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL mt_no_busy: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_ops(input string name, input logic [5:0] fs[], input logic [31:0] xs[], input logic [31:0] ys[]);
        int cyc;
        logic [31:0] h, l;
        logic b1, b33, da;
        logic [63:0] exp;
        for (int i = 0; i < fs.size(); i++) begin
            run_op(fs[i], xs[i], ys[i], cyc, h, l, b1, b33, da);
            exp = pop_exp();
            checks++;
            if (cyc !== latency(fs[i], ys[i])) begin
                failures++;
                $display("FAIL %s_latency[%0d]: got done at cycle %0d expected %0d", name, i, cyc, latency(fs[i], ys[i]));
            end
            checks++;
            if ({h, l} !== exp) begin
                failures++;
                $display("FAIL %s_result[%0d]: got hi=%h lo=%h expected hi=%h lo=%h", name, i, h, l, exp[63:32], exp[31:0]);
            end
            checks++;
            if (da !== 1'b0) begin
                failures++;
                $display("FAIL %s_done_pulse[%0d]: got done=%b one cycle later expected 0", name, i, da);
            end
            if (latency(fs[i], ys[i]) > 2) begin
                checks++;
                if (b1 !== 1'b1 || b33 !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_busy[%0d]: got busy c1=%b c33=%b expected 1 1", name, i, b1, b33);
                end
            end
        end
    endtask

    task automatic test_mult();
        test_ops("mult", '{F_MULTU, F_MULT, F_MULT, F_MULTU},
                 '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0},
                 '{32'hFFFFFFFF, 32'h7, 32'hFFFFFFF7, 32'h1234});
    endtask

    task automatic test_div();
        test_ops("div", '{F_DIV, F_DIVU, F_DIV, F_DIV, F_DIV, F_DIVU, F_DIVU},
                 '{32'hFFFFFFF9, 32'd100, 32'd5, 32'h80000000, 32'd7, 32'hFFFFFFFF, 32'd3},
                 '{32'd2, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h10, 32'd0});
    endtask

    task automatic test_stall();
        int cyc, bad;
        logic [63:0] exp;
        logic [31:0] h, l;
        @(negedge CLK);
        bus.start = 1'b1; bus.funct = F_MULT; bus.Rdata1 = 32'd6; bus.Rdata2 = 32'hFFFFFFF9;
        sb_q.push_back(model(F_MULT, 32'd6, 32'hFFFFFFF9));
        @(posedge CLK); #1 bus.start = 1'b0; bus.mf_req = 1'b1;
        cyc = -1; bad = 0; h = '0; l = '0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge CLK);
            if (bus.done) begin
                cyc = k; h = bus.hi; l = bus.lo;
                if (bus.stall !== 1'b0) bad++;
                break;
            end else if (bus.stall !== 1'b1) bad++;
        end
        bus.mf_req = 1'b0;
        exp = pop_exp();
        checks++;
        if (cyc !== 34 || bad !== 0) begin
            failures++;
            $display("FAIL mf_stall: got done cycle %0d bad stall cycles %0d expected 34 and 0", cyc, bad);
        end
        checks++;
        if ({h, l} !== exp) begin
            failures++;
            $display("FAIL mf_stall_result: got %h expected %h", {h, l}, exp);
        end

        @(negedge CLK);
        bus.start = 1'b1; bus.funct = F_DIVU; bus.Rdata1 = 32'd100; bus.Rdata2 = 32'd7;
        sb_q.push_back(model(F_DIVU, 32'd100, 32'd7));
        @(posedge CLK); #1 bus.funct = F_MTHI; bus.Rdata1 = 32'h0000DEAD;
        cyc = -1; bad = -1; h = '0; l = '0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge CLK);
            if (bus.done) begin cyc = k; h = bus.hi; l = bus.lo; end
            if (!bus.stall) begin bad = k; break; end
        end
        @(posedge CLK); #1 bus.start = 1'b0;
        exp = pop_exp();
        checks++;
        if (cyc !== 34 || bad !== 35) begin
            failures++;
            $display("FAIL start_stall: got done cycle %0d accept cycle %0d expected 34 and 35", cyc, bad);
        end
        checks++;
        if ({h, l} !== exp) begin
            failures++;
            $display("FAIL start_stall_result: got %h expected %h", {h, l}, exp);
        end
        @(negedge CLK);
        checks++;
        if (bus.hi !== 32'h0000DEAD || bus.lo !== exp[31:0]) begin
            failures++;
            $display("FAIL represent_mthi: got hi=%h lo=%h expected hi=0000dead lo=%h", bus.hi, bus.lo, exp[31:0]);
        end
    endtask

    task automatic test_flush();
        int dones;
        mt(F_MTHI, 32'hAAAA_0000);
        mt(F_MTLO, 32'h0000_5555);
        @(negedge CLK);
        bus.start = 1'b1; bus.funct = F_MULT; bus.Rdata1 = 32'd3; bus.Rdata2 = 32'd4;
        @(posedge CLK); #1 bus.start = 1'b0;
        repeat (10) @(negedge CLK);
        bus.flush = 1'b1;
        @(posedge CLK); #1 bus.flush = 1'b0;
        dones = 0;
        @(negedge CLK);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle: got busy=%b expected 0", bus.busy);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (bus.done) dones++;
        end
        checks++;
        if (dones !== 0 || bus.hi !== 32'hAAAA_0000 || bus.lo !== 32'h0000_5555) begin
            failures++;
            $display("FAIL flush_hold: got dones=%0d hi=%h lo=%h expected 0 aaaa0000 00005555", dones, bus.hi, bus.lo);
        end
        bus.start = 1'b1; bus.funct = F_MTHI; bus.Rdata1 = 32'h0000BEEF; bus.flush = 1'b1;
        @(posedge CLK); #1 bus.start = 1'b0; bus.flush = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.hi !== 32'hAAAA_0000) begin
            failures++;
            $display("FAIL flush_beats_start: got hi=%h expected aaaa0000", bus.hi);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        @(negedge CLK);
        bus.start = 1'b1; bus.funct = F_DIV; bus.Rdata1 = 32'd100; bus.Rdata2 = 32'd3;
        @(posedge CLK); #1 bus.start = 1'b0;
        repeat (5) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        checks++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got hi=%h lo=%h busy=%b done=%b expected zeros", bus.hi, bus.lo, bus.busy, bus.done);
        end
        @(negedge CLK);
        RST = 1'b1;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (bus.done) dones++;
        end
        checks++;
        if (dones !== 0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_after: got dones=%0d hi=%h lo=%h expected 0 0 0", dones, bus.hi, bus.lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] fs[];
        logic [31:0] xs[], ys[];
        logic [5:0] codes[4];
        codes = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        fs = new[6]; xs = new[6]; ys = new[6];
        for (int i = 0; i < 6; i++) begin
            fs[i] = codes[$urandom_range(0, 3)];
            xs[i] = $urandom;
            ys[i] = (i == 5) ? 32'd0 : $urandom;
        end
        test_ops("b2b", fs, xs, ys);
    endtask

    initial begin
        bus.start = 1'b0; bus.funct = '0; bus.Rdata1 = '0; bus.Rdata2 = '0;
        bus.mf_req = 1'b0; bus.flush = 1'b0;
        test_reset();
        test_mthi_mtlo();
        test_mult();
        test_div();
        test_stall();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
